// File: rtl/mem_pkg.sv
// Shared definitions for the multicycle MIPS memory responder and the control unit's wait logic.
package mem_pkg;

    localparam logic [1:0] RAM_BYTE = 2'b00;
    localparam logic [1:0] RAM_HALF = 2'b01;
    localparam logic [1:0] RAM_WORD = 2'b10;
    localparam logic [1:0] RAM_RSVD = 2'b11;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_BUSY = 2'd1,
        MS_DONE = 2'd2
    } mem_state_e;

    // Offset of the last byte touched by an access of the given size.
    function automatic logic [1:0] ram_last_ofs(input logic [1:0] ram_type);
        logic [1:0] ofs;
        case (ram_type)
            RAM_BYTE: ofs = 2'd0;
            RAM_HALF: ofs = 2'd1;
            default:  ofs = 2'd3;
        endcase
        return ofs;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane select/merge for loads and stores, with sign/zero extension of
// byte and halfword loads. Expects addr_lo already aligned for halfword/word accesses.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  ram_type,
    input  logic [1:0]  addr_lo,
    input  logic        is_signed,
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [31:0] wr_word,
    output logic [3:0]  byte_en
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        rd_data  = rd_word;
        wr_word  = wr_data;
        byte_en  = 4'b0000;

        // Byte offset 0 is the most significant lane.
        case (addr_lo)
            2'd0:    byte_sel = rd_word[31:24];
            2'd1:    byte_sel = rd_word[23:16];
            2'd2:    byte_sel = rd_word[15:8];
            default: byte_sel = rd_word[7:0];
        endcase
        half_sel = addr_lo[1] ? rd_word[15:0] : rd_word[31:16];

        case (ram_type)
            RAM_BYTE: begin
                rd_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
                wr_word = {4{wr_data[7:0]}};
                byte_en = 4'b1000 >> addr_lo;
            end
            RAM_HALF: begin
                rd_data = {{16{is_signed & half_sel[15]}}, half_sel};
                wr_word = {2{wr_data[15:0]}};
                byte_en = addr_lo[1] ? 4'b0011 : 4'b1100;
            end
            RAM_WORD: begin
                byte_en = 4'b1111;
            end
            default: begin
                rd_data = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Byte-addressed big-endian memory with a MemRead/MemWrite -> MOC handshake and LATENCY wait
// states. Define MEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of forcing alignment.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  ramType,
    input  logic        isSigned,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        Err
);

    localparam int unsigned        WORDS    = 2 ** (ADDR_W - 2);
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(LATENCY - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      dout_q, dout_d;

    logic             rd_q, wr_q, sign_q;
    logic [1:0]       type_q;
    logic [31:0]      addr_q, wdata_q;

    logic [31:0]      mem [WORDS];

    logic              req, commit, fault, misalign;
    logic [ADDR_W-1:0] eff_addr;
    logic [ADDR_W:0]   last_byte;
    logic [31:0]       rd_word, rd_data, wr_word;
    logic [3:0]        byte_en;

    assign req = MemRead | MemWrite;

    always_comb begin
        eff_addr = addr_q[ADDR_W-1:0];
        if (type_q == RAM_HALF) eff_addr[0] = 1'b0;
        if (type_q == RAM_WORD) eff_addr[1:0] = 2'b00;
    end

    // Carry out of the last-byte address means the access runs past the implemented range.
    assign last_byte = {1'b0, eff_addr} + (ADDR_W + 1)'(ram_last_ofs(type_q));

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ((type_q == RAM_HALF) && addr_q[0]) ||
                      ((type_q == RAM_WORD) && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign fault = (rd_q & wr_q) | (type_q == RAM_RSVD) | (|addr_q[31:ADDR_W]) |
                   last_byte[ADDR_W] | misalign;

    assign rd_word = mem[eff_addr[ADDR_W-1:2]];

    mem_lane_align u_lane (
        .ram_type  (type_q),
        .addr_lo   (eff_addr[1:0]),
        .is_signed (sign_q),
        .rd_word   (rd_word),
        .wr_data   (wdata_q),
        .rd_data   (rd_data),
        .wr_word   (wr_word),
        .byte_en   (byte_en)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        dout_d  = dout_q;
        commit  = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (req) begin
                    state_d = MS_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            MS_BUSY: begin
                if (!req) begin
                    state_d = MS_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = MS_DONE;
                    commit  = 1'b1;
                    err_d   = fault;
                    if (fault) begin
                        dout_d = 32'h0;
                    end else if (rd_q) begin
                        dout_d = rd_data;
                    end
                end
            end
            MS_DONE: begin
                if (!req) begin
                    state_d = MS_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = MS_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Request inputs are captured only on the accepting edge; later changes are ignored.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            sign_q  <= 1'b0;
            type_q  <= RAM_BYTE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (state_q == MS_IDLE && req) begin
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            sign_q  <= isSigned;
            type_q  <= ramType;
            addr_q  <= Address;
            wdata_q <= DataIn;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit && wr_q && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[eff_addr[ADDR_W-1:2]][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    assign MOC     = (state_q == MS_DONE);
    assign Err     = err_q;
    assign DataOut = dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized accesses checked
// against a byte-array reference model. Honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned LATENCY   = 2;
    localparam int unsigned MEM_BYTES = 1 << ADDR_W;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        RESET;
    logic        MemRead, MemWrite, isSigned;
    logic [1:0]  ramType;
    logic [31:0] Address, DataIn, DataOut;
    logic        MOC, Err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_mem [MEM_BYTES];

    mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk      (clk),
        .RESET    (RESET),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ramType  (ramType),
        .isSigned (isSigned),
        .Address  (Address),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .MOC      (MOC),
        .Err      (Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: fault rules, aligned effective address, big-endian byte order, extension.
    function automatic void model(input bit rd, input bit wr, input logic [1:0] typ,
                                  input bit sgn, input logic [31:0] a, input logic [31:0] d,
                                  output bit e, output logic [31:0] q);
        int unsigned nb, base;
        logic [31:0] v;
        nb   = (typ == 2'b00) ? 1 : (typ == 2'b01) ? 2 : 4;
        base = a - (a % nb);
        e = (rd && wr) || (typ == 2'b11) || (a >= MEM_BYTES) || (base + nb > MEM_BYTES);
        if (TRAP && (a % nb) != 0) e = 1'b1;
        q = 32'h0;
        if (!e && rd) begin
            v = 32'h0;
            for (int i = 0; i < int'(nb); i++) v = (v << 8) | 32'(model_mem[base + i]);
            if (nb < 4 && sgn && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            q = v;
        end
        if (!e && wr) begin
            for (int i = 0; i < int'(nb); i++)
                model_mem[base + i] = 8'(d >> (8*(nb - 1 - i)));
        end
    endfunction

    task automatic access(input bit rd, input bit wr, input logic [1:0] typ, input bit sgn,
                          input logic [31:0] a, input logic [31:0] d, input int hold,
                          output logic [31:0] got, output logic got_err);
        bit          exp_e;
        logic [31:0] exp_q;
        int          n;
        model(rd, wr, typ, sgn, a, d, exp_e, exp_q);
        @(negedge clk);
        MemRead = rd; MemWrite = wr; ramType = typ; isSigned = sgn; Address = a; DataIn = d;
        n = 0;
        while (n < 50 && !MOC) begin
            @(negedge clk);
            n++;
        end
        check_eq("moc_latency", n, LATENCY + 1);
        got     = DataOut;
        got_err = Err;
        check_eq("err", Err, exp_e);
        if (rd || exp_e) check_eq("dataout", DataOut, exp_q);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("moc_hold", MOC, 1);
        end
        MemRead = 0; MemWrite = 0;
        @(negedge clk);
        check_eq("moc_clear", MOC, 0);
        check_eq("err_clear", Err, 0);
    endtask

    task automatic abort_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemRead = 0; MemWrite = 1; ramType = RAM_WORD; isSigned = 0; Address = a; DataIn = d;
        @(negedge clk);
        MemWrite = 0;
        @(negedge clk);
        check_eq("abort_moc", MOC, 0);
        @(negedge clk);
        check_eq("abort_moc2", MOC, 0);
    endtask

    initial begin
        logic [31:0] got;
        logic        ge;
        RESET = 0; MemRead = 0; MemWrite = 0; ramType = RAM_BYTE; isSigned = 0;
        Address = 0; DataIn = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_moc", MOC, 0);
        check_eq("rst_err", Err, 0);
        check_eq("rst_dout", DataOut, 0);
        RESET = 1;

        for (int w = 0; w < int'(MEM_BYTES / 4); w++)
            access(0, 1, RAM_WORD, 0, 32'(w * 4), $urandom, 0, got, ge);

        access(0, 1, RAM_WORD, 0, 32'h10, 32'hDEAD_BEEF, 0, got, ge);
        access(1, 0, RAM_WORD, 0, 32'h10, 32'h0, 0, got, ge);
        check_eq("word_rd", got, 32'hDEAD_BEEF);
        access(1, 0, RAM_BYTE, 0, 32'h10, 32'h0, 0, got, ge);
        check_eq("byte_msb", got, 32'h0000_00DE);

        access(0, 1, RAM_BYTE, 0, 32'h21, 32'h0000_0080, 0, got, ge);
        access(1, 0, RAM_BYTE, 1, 32'h21, 32'h0, 0, got, ge);
        check_eq("byte_signed", got, 32'hFFFF_FF80);
        access(1, 0, RAM_BYTE, 0, 32'h21, 32'h0, 0, got, ge);
        check_eq("byte_unsigned", got, 32'h0000_0080);
        access(1, 0, RAM_BYTE, 0, 32'h20, 32'h0, 0, got, ge);
        access(1, 0, RAM_BYTE, 0, 32'h22, 32'h0, 0, got, ge);

        access(0, 1, RAM_WORD, 0, 32'h30, 32'h1122_3344, 0, got, ge);
        access(0, 1, RAM_HALF, 0, 32'h32, 32'h0000_ABCD, 0, got, ge);
        access(1, 0, RAM_WORD, 0, 32'h30, 32'h0, 0, got, ge);
        check_eq("half_merge", got, 32'h1122_ABCD);

        access(0, 1, RAM_RSVD, 0, 32'h30, 32'h5555_5555, 0, got, ge);
        check_eq("fault_rsvd", ge, 1);
        access(0, 1, RAM_WORD, 0, 32'h200, 32'h5555_5555, 0, got, ge);
        check_eq("fault_range", ge, 1);
        access(1, 1, RAM_WORD, 0, 32'h30, 32'h5555_5555, 0, got, ge);
        check_eq("fault_both", ge, 1);
        access(1, 0, RAM_WORD, 0, 32'h30, 32'h0, 0, got, ge);
        check_eq("fault_nochange", got, 32'h1122_ABCD);

        access(1, 0, RAM_WORD, 0, 32'h41, 32'h0, 3, got, ge);
        check_eq("misalign_err", ge, TRAP);

        abort_write(32'h30, 32'hAAAA_AAAA);
        access(1, 0, RAM_WORD, 0, 32'h30, 32'h0, 0, got, ge);
        check_eq("abort_nowrite", got, 32'h1122_ABCD);

        // Reset one edge into a write: no commit, outputs cleared asynchronously.
        @(negedge clk);
        MemWrite = 1; ramType = RAM_WORD; Address = 32'h10; DataIn = 32'hCAFE_F00D;
        @(negedge clk);
        RESET = 0;
        #1;
        check_eq("rst_busy_moc", MOC, 0);
        check_eq("rst_busy_dout", DataOut, 0);
        MemWrite = 0;
        @(negedge clk);
        RESET = 1;
        access(1, 0, RAM_WORD, 0, 32'h10, 32'h0, 0, got, ge);
        check_eq("rst_busy_nowrite", got, 32'hDEAD_BEEF);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            logic [1:0]  t;
            int unsigned op;
            a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES - 1));
            t  = ($urandom_range(0, 15) == 0) ? RAM_RSVD : 2'($urandom_range(0, 2));
            op = $urandom_range(0, 19);
            if (op == 0) begin
                abort_write(32'($urandom_range(0, MEM_BYTES / 4 - 1) * 4), $urandom);
            end else begin
                access(op < 10 || op == 19, op >= 10, t, 1'($urandom), a, $urandom,
                       int'($urandom_range(0, 2)), got, ge);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle MIPS datapath. It services the load/store requests that the datapath issues via MemRead/MemWrite, ramType and the ALU address.
- Byte-addressed, big-endian storage with a four-phase request/MOC (memory operation complete) handshake and programmable access latency.
- Replaces the zero-latency RAM model so the control unit can be exercised against wait states.

Parameters:
- ADDR_W, 9: byte-address bits implemented (2^ADDR_W bytes).
- LATENCY, 2: number of BUSY cycles per access; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MemRead  in  1  read request; held until MOC observed.
- MemWrite  in  1  write request; held until MOC observed.
- ramType  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- isSigned  in  1  sign-extend byte/halfword reads (1) or zero-extend (0).
- Address  in  32  byte address from ALUResult.
- DataIn  in  32  store data from readdata2; the value is in the low bits for byte/halfword.
- DataOut  out  32  load data, extended to 32 bits.
- MOC  out  1  operation complete.
- Err  out  1  access fault; valid while MOC=1.

Behaviour:
- Reset (RESET=0, asynchronous): state goes to IDLE; MOC=0, Err=0, DataOut=0. Storage contents are NOT cleared.
- States and transitions:
  - IDLE: on the edge that samples MemRead|MemWrite=1, latch Address, ramType, isSigned, DataIn and the op. Then go to BUSY with cnt=LATENCY-1.
  - BUSY: each edge with cnt≠0 decrements cnt. On the edge with cnt==0, go to DONE and set MOC=1. At the same edge, commit the write (if any) and register DataOut (if read).
  - DONE: hold MOC, Err and DataOut stable until MemRead and MemWrite are both 0. On that edge, clear MOC and Err and return to IDLE. DataOut retains its last value.
- Latency: MOC rises on the LATENCY-th edge after the sampling edge. With LATENCY=2, a request sampled at edge 0 gives MOC=1 after edge 2.
- Request withdrawn during BUSY (both strobes low): abort, go to IDLE, perform no write, keep MOC=0.
- Byte order is big-endian. Byte at A maps to bits [31:24] of the word at A&~3. Halfword at A occupies bytes A and A+1, MSB first.
- Reads: byte/halfword data is sign- or zero-extended per the latched isSigned. Word reads are returned unmodified.
- Writes: only the addressed bytes change. Byte writes use DataIn[7:0]; halfword writes use DataIn[15:0].
- Fault conditions; each completes normally with MOC=1 and Err=1, with no storage change and DataOut=0:
  - Both MemRead and MemWrite=1 when sampled.
  - ramType=11.
  - Address[31:ADDR_W] ≠ 0.
  - Misalignment (see Optional Feature).
- Address wrap-around is not supported. A halfword/word whose last byte exceeds the implemented range is an out-of-range fault.
- Request inputs are ignored outside IDLE. Only the latched copies are used.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a halfword with Address[0]=1, or a word with Address[1:0]≠0, gives Err=1 and no access.
- Undefined: low address bits are forced to alignment (halfword A&~1, word A&~3) and the access proceeds with Err=0.

Decomposition:
- Shared package mem_pkg holds:
  - RAM_BYTE=2'b00, RAM_HALF=2'b01, RAM_WORD=2'b10.
  - State encodings MS_IDLE, MS_BUSY, MS_DONE.
  - Any constants reused by the control unit's wait logic.
- One natural sub-module: mem_lane_align. It is combinational and performs byte-lane select/merge and sign/zero extension from ramType, Address[1:0] and isSigned.
- The FSM and storage array live in mem_responder.

Test Plan:
- Reset mid-BUSY: assert a word write, then drop RESET after 1 edge. MOC=0, DataOut=0, state IDLE. A subsequent read of that address returns the prior contents (no write).
- Word store then load, LATENCY=2: write 0xDEADBEEF to addr 0x10, then read word 0x10. MOC appears 2 edges after sampling in both cases. DataOut=0xDEADBEEF; byte 0x10 reads 0xDE.
- Byte loads: write byte 0x80 to addr 0x21. Signed byte read gives 0xFFFFFF80; unsigned byte read gives 0x00000080. Neighbouring bytes 0x20/0x22 are unchanged.
- Halfword store into word 0x30=0x11223344: store DataIn=0x0000ABCD at addr 0x32, then read word 0x30. Result is 0x1122ABCD.
- Faults:
  - ramType=11 gives Err=1, MOC=1.
  - Address 0x200 (ADDR_W=9) gives Err=1.
  - MemRead and MemWrite both 1 gives Err=1.
  - Storage is unchanged in every case.
- Misaligned word read at 0x41: with MEM_MISALIGN_TRAP_EN, Err=1 and DataOut=0. Without it, Err=0 and DataOut equals the word at 0x40. Hold the request 3 cycles after MOC, then drop it: MOC stays high until the drop and clears on the next edge.
